// File: rtl/bru_pkg.sv
// Shared types and default parameters for the branch resolve unit.
// Optional statistics counters are enabled with the BRU_STATS_EN macro.
package bru_pkg;

    localparam int BRU_DEPTH = 4;
    localparam int BRU_PC_W  = 8;
    localparam int BRU_CNT_W = 16;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bru_state_e;

    // Entry layout at the default PC width; the FIFO stores the same
    // {pc, taken} packing for any PC_W.
    typedef struct packed {
        logic [BRU_PC_W-1:0] pc;
        logic                taken;
    } bru_entry_t;

endpackage

// File: rtl/bru_fifo.sv
// In-order storage of outstanding predictions: {pc, taken} per entry,
// with push, pop and clear; clear wins over a push in the same cycle.
module bru_fifo
    import bru_pkg::*;
#(
    parameter int DEPTH = BRU_DEPTH,
    parameter int PC_W  = BRU_PC_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [PC_W-1:0] wr_pc,
    input  logic            wr_taken,
    input  logic            pop,
    input  logic            clear,
    output logic            full,
    output logic            empty,
    output logic [PC_W-1:0] head_pc,
    output logic            head_taken
);

    localparam int AW = $clog2(DEPTH);

    logic [PC_W:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            push_ok;
    logic            pop_ok;
    logic [PC_W:0]   head_word;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full && !clear;
    assign pop_ok  = pop && !empty;

    // Head is read asynchronously: the compare happens in the same cycle
    // the resolution arrives.
    assign head_word  = mem_q[rd_ptr_q];
    assign head_pc    = head_word[PC_W:1];
    assign head_taken = head_word[0];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {wr_pc, wr_taken};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Compares in-flight branch predictions with execute-stage outcomes, trains
// the predictor and flushes on a miss. Statistics need BRU_STATS_EN.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int DEPTH = BRU_DEPTH,
    parameter int PC_W  = BRU_PC_W,
    parameter int CNT_W = BRU_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid,
    input  logic             pred_taken,
    input  logic [PC_W-1:0]  pred_pc,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    output logic             upd_request,
    output logic             upd_taken,
    output logic             mispredict,
    output logic [PC_W-1:0]  mis_pc,
    output logic             res_err,
    output logic [CNT_W-1:0] stat_total,
    output logic [CNT_W-1:0] stat_miss
);

    bru_state_e      state_q, state_d;
    logic            fifo_full;
    logic            fifo_empty;
    logic [PC_W-1:0] head_pc;
    logic            head_taken;
    logic            in_run;
    logic            push;
    logic            res_ok;
    logic            miss;

    logic            upd_request_q, upd_request_d;
    logic            upd_taken_q, upd_taken_d;
    logic            mispredict_q, mispredict_d;
    logic [PC_W-1:0] mis_pc_q, mis_pc_d;
    logic            res_err_q, res_err_d;

    bru_fifo #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .wr_pc      (pred_pc),
        .wr_taken   (pred_taken),
        .pop        (res_ok),
        .clear      (miss),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_pc    (head_pc),
        .head_taken (head_taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A resolution during FLUSH finds nothing to pop: the FIFO was just
    // cleared, so it is reported as an orphan like an empty-FIFO one.
    always_comb begin
        state_d = state_q;
        in_run  = 1'b0;
        case (state_q)
            RUN: begin
                in_run = 1'b1;
                if (miss) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign pred_ready = in_run && !fifo_full;
    assign push       = pred_valid && pred_ready;
    assign res_ok     = res_valid && in_run && !fifo_empty;
    assign miss       = res_ok && (head_taken != res_taken);

    always_comb begin
        upd_request_d = res_ok;
        upd_taken_d   = res_ok && res_taken;
        mispredict_d  = miss;
        mis_pc_d      = miss ? head_pc : '0;
        res_err_d     = res_err_q || (res_valid && !res_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_request_q <= 1'b0;
            upd_taken_q   <= 1'b0;
            mispredict_q  <= 1'b0;
            mis_pc_q      <= '0;
            res_err_q     <= 1'b0;
        end else begin
            upd_request_q <= upd_request_d;
            upd_taken_q   <= upd_taken_d;
            mispredict_q  <= mispredict_d;
            mis_pc_q      <= mis_pc_d;
            res_err_q     <= res_err_d;
        end
    end

    assign upd_request = upd_request_q;
    assign upd_taken   = upd_taken_q;
    assign mispredict  = mispredict_q;
    assign mis_pc      = mis_pc_q;
    assign res_err     = res_err_q;

`ifdef BRU_STATS_EN
    logic [CNT_W-1:0] stat_total_q;
    logic [CNT_W-1:0] stat_miss_q;

    // Saturating: once all-ones the counter is simply never written again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_total_q <= '0;
            stat_miss_q  <= '0;
        end else begin
            if (res_ok && (stat_total_q != '1)) begin
                stat_total_q <= stat_total_q + CNT_W'(1);
            end
            if (miss && (stat_miss_q != '1)) begin
                stat_miss_q <= stat_miss_q + CNT_W'(1);
            end
        end
    end

    assign stat_total = stat_total_q;
    assign stat_miss  = stat_miss_q;
`else
    assign stat_total = '0;
    assign stat_miss  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; statistics expectations follow
// BRU_STATS_EN (counts when defined, zero otherwise).
module tb_branch_resolve_unit;

`ifdef BRU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic        pred_taken;
    logic [7:0]  pred_pc;
    logic        pred_ready;
    logic        res_valid;
    logic        res_taken;
    logic        upd_request;
    logic        upd_taken;
    logic        mispredict;
    logic [7:0]  mis_pc;
    logic        res_err;
    logic [15:0] stat_total;
    logic [15:0] stat_miss;

    int checks = 0;
    int errors = 0;

    branch_resolve_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pred_valid  (pred_valid),
        .pred_taken  (pred_taken),
        .pred_pc     (pred_pc),
        .pred_ready  (pred_ready),
        .res_valid   (res_valid),
        .res_taken   (res_taken),
        .upd_request (upd_request),
        .upd_taken   (upd_taken),
        .mispredict  (mispredict),
        .mis_pc      (mis_pc),
        .res_err     (res_err),
        .stat_total  (stat_total),
        .stat_miss   (stat_miss)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sexp(input logic [31:0] v);
        return STATS ? v : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1ns after the edge.
    task automatic drive(input logic pv, input logic pt, input logic [7:0] pc,
                         input logic rv, input logic rt);
        pred_valid = pv;
        pred_taken = pt;
        pred_pc    = pc;
        res_valid  = rv;
        res_taken  = rt;
        @(posedge clk);
        #1;
        $display("txn: pv=%0b pt=%0b pc=0x%02h rv=%0b rt=%0b -> rdy=%0b upd=%0b/%0b mis=%0b mis_pc=0x%02h err=%0b tot=%0d miss=%0d",
                 pv, pt, pc, rv, rt, pred_ready, upd_request, upd_taken, mispredict,
                 mis_pc, res_err, stat_total, stat_miss);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"},   32'(pred_ready),  32'd1);
        check({tag, "_upd_req"}, 32'(upd_request), 32'd0);
        check({tag, "_upd_tk"},  32'(upd_taken),   32'd0);
        check({tag, "_mis"},     32'(mispredict),  32'd0);
        check({tag, "_mis_pc"},  32'(mis_pc),      32'd0);
        check({tag, "_res_err"}, 32'(res_err),     32'd0);
        check({tag, "_total"},   32'(stat_total),  32'd0);
        check({tag, "_miss"},    32'(stat_miss),   32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        pred_valid = 1'b0; pred_taken = 1'b0; pred_pc = 8'h00;
        res_valid = 1'b0;  res_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        // Correct prediction
        drive(1, 1, 8'h10, 0, 0);
        drive(0, 0, 8'h00, 1, 1);
        check("hit_upd_req", 32'(upd_request), 32'd1);
        check("hit_upd_tk",  32'(upd_taken),   32'd1);
        check("hit_mis",     32'(mispredict),  32'd0);
        check("hit_total",   32'(stat_total),  sexp(1));
        drive(0, 0, 8'h00, 0, 0);
        check("hit_pulse_end", 32'(upd_request), 32'd0);

        // Mispredict of the oldest entry discards the younger two
        drive(1, 0, 8'h20, 0, 0);
        drive(1, 1, 8'h24, 0, 0);
        drive(1, 1, 8'h28, 0, 0);
        drive(0, 0, 8'h00, 1, 1);
        check("miss_flag",   32'(mispredict),  32'd1);
        check("miss_pc",     32'(mis_pc),      32'h20);
        check("miss_ready",  32'(pred_ready),  32'd0);
        check("miss_upd_tk", 32'(upd_taken),   32'd1);
        check("miss_total",  32'(stat_total),  sexp(2));
        check("miss_count",  32'(stat_miss),   sexp(1));
        drive(0, 0, 8'h00, 0, 0);
        check("flush_end_mis",   32'(mispredict), 32'd0);
        check("flush_end_ready", 32'(pred_ready), 32'd1);

        // Fill to DEPTH; ready drops only after the fourth push
        drive(1, 0, 8'h30, 0, 0);
        drive(1, 1, 8'h31, 0, 0);
        drive(1, 0, 8'h32, 0, 0);
        check("fill3_ready", 32'(pred_ready), 32'd1);
        drive(1, 1, 8'h33, 0, 0);
        check("full_ready", 32'(pred_ready), 32'd0);
        // Push while full is refused; the pop still happens
        drive(1, 0, 8'h40, 1, 0);
        check("full_pop_upd", 32'(upd_request), 32'd1);
        check("full_pop_mis", 32'(mispredict),  32'd0);
        check("full_pop_rdy", 32'(pred_ready),  32'd1);
        // Push and pop together leave the count at 3
        drive(1, 1, 8'h41, 1, 1);
        check("pushpop_rdy", 32'(pred_ready), 32'd1);
        check("pushpop_mis", 32'(mispredict), 32'd0);
        check("pushpop_tk",  32'(upd_taken),  32'd1);
        drive(1, 0, 8'h42, 0, 0);
        check("refill_ready", 32'(pred_ready),  32'd0);
        check("refill_upd",   32'(upd_request), 32'd0);
        // Head is now 0x32 (predicted not-taken)
        drive(0, 0, 8'h00, 1, 1);
        check("head32_mis",   32'(mispredict), 32'd1);
        check("head32_pc",    32'(mis_pc),     32'h32);
        check("head32_total", 32'(stat_total), sexp(5));
        check("head32_miss",  32'(stat_miss),  sexp(2));
        drive(0, 0, 8'h00, 0, 0);
        check("head32_after_rdy", 32'(pred_ready), 32'd1);

        // Orphan resolution
        drive(0, 0, 8'h00, 1, 1);
        check("orphan_upd",   32'(upd_request), 32'd0);
        check("orphan_err",   32'(res_err),     32'd1);
        check("orphan_total", 32'(stat_total),  sexp(5));
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 8'h00, 0, 0);
        end
        check("err_sticky", 32'(res_err), 32'd1);

        // Saturation
`ifdef BRU_STATS_EN
        force dut.stat_total_q = 16'hFFFF;
        drive(0, 0, 8'h00, 0, 0);
        release dut.stat_total_q;
`endif
        drive(1, 1, 8'h70, 0, 0);
        drive(0, 0, 8'h00, 1, 1);
        check("sat_upd",   32'(upd_request), 32'd1);
        check("sat_total", 32'(stat_total),  sexp(32'hFFFF));
        check("sat_miss",  32'(stat_miss),   sexp(2));

        // Reset with three entries pending and a mispredict about to be registered
        drive(1, 0, 8'h60, 0, 0);
        drive(1, 1, 8'h61, 0, 0);
        drive(1, 1, 8'h62, 0, 0);
        pred_valid = 1'b0;
        res_valid  = 1'b1;
        res_taken  = 1'b1;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("midrst");
        rst = 1'b0;
        drive(0, 0, 8'h00, 0, 0);
        drive(0, 0, 8'h00, 1, 1);
        check("post_rst_upd", 32'(upd_request), 32'd0);
        check("post_rst_err", 32'(res_err),     32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
